id_hazard_sched: RTL and testbench
==================================

// Module: id_hazard_sched
// PURPOSE
//  Issue/write-back controller around the ID-stage register file.
//  - Keeps a busy-bit scoreboard of pending register writes and stalls ID on RAW/WAW hazards (no forwarding).
//  - Shares the single regfile write port between pipeline WB and the multi-cycle MDU result path.
//  - Guarantees the MDU a slot through a starvation FSM that injects ID stalls.
// PARAMETERS
//  NREG       32  number of architectural registers (r0 hard-wired zero)
//  AW         5   register address width, $clog2(NREG)
//  DW         32  register data width
//  STARVE_MAX 4   cycles the MDU may lose arbitration before forced drain (>=1)
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  id_valid      in   1   instruction present in ID
//  id_rs, id_rt  in   AW  source register fields
//  id_use_rs/rt  in   1   source actually read
//  id_wr_en      in   1   instruction will write a register
//  id_wr_rd      in   AW  destination register
//  id_stall      out  1   hold IF/ID, insert bubble into ID/EX
//  id_issue      out  1   id_valid & ~id_stall
//  pipe_wb_valid in   1   pipeline WB write this cycle (cannot be held off)
//  pipe_wb_rd    in   AW  pipeline WB destination
//  pipe_wb_wd    in   DW  pipeline WB data
//  mdu_wb_valid  in   1   MDU result offered
//  mdu_wb_rd     in   AW  MDU destination
//  mdu_wb_wd     in   DW  MDU data
//  mdu_wb_ready  out  1   MDU result accepted this cycle
//  rf_we, rf_wa, rf_wd   out 1/AW/DW  regfile write port (wb_reg_write/wb_rd/wb_wd)
// BEHAVIOUR
//  - State: busy[NREG-1:1] and starve_cnt reset to 0; arb_state resets to ARB_IDLE.
//  - While rst_n=0, rf_we=0 and mdu_wb_ready=0. Reset mid-operation discards all pending marks.
//  - Write port, combinational:
//      - pipe_wb_valid=1: pipeline drives the port.
//      - else mdu_wb_valid=1: MDU drives the port and mdu_wb_ready=1.
//      - rf_we is suppressed when the selected rd==0.
//  - Scoreboard, per cycle: busy_n = (busy & ~clr) | set.
//      - clr = onehot(rf_wa) when rf_we.
//      - set = onehot(id_wr_rd) when id_issue & id_wr_en & id_wr_rd!=0.
//      - Set wins when set and clear hit the same register.
//  - id_stall = id_valid & (raw | waw | arb_state==ARB_DRAIN).
//      - raw = (id_use_rs & busy[id_rs]) | (id_use_rt & busy[id_rt]).
//      - waw = id_wr_en & busy[id_wr_rd].
//      - r0 is never busy.
//  - Arbiter FSM (a lost cycle = mdu_wb_valid & pipe_wb_valid):
//      - IDLE->WAIT on a lost cycle; starve_cnt<=1.
//      - WAIT->IDLE on grant; starve_cnt<=0.
//      - WAIT: on a lost cycle, starve_cnt++; at starve_cnt==STARVE_MAX go to DRAIN.
//      - DRAIN: id_stall forced for any id_valid; bubbles reach WB and free the port; DRAIN->IDLE on grant.
//      - mdu_wb_valid dropping without a grant returns the FSM to IDLE.
//  - MDU must hold rd/wd stable while valid & ~ready.
// CONFIGURATION
//  ID_BYPASS_EN defined:
//    - The register written this cycle (rf_we, rf_wa) is treated as not busy for raw/waw, so ID issues in the write cycle.
//    - Adds outputs byp_rs/byp_rt (1b) and byp_wd (DW), so ID muxes rf_wd over the stale read value.
//  ID_BYPASS_EN undefined:
//    - Hazard ends one cycle after the write.
//    - No byp_* ports.
// STRUCTURE
//  - Package hazard_pkg: reg_addr_t, arb_state_t {ARB_IDLE,ARB_WAIT,ARB_DRAIN}, REG_ZERO constant.
//  - Sub-module wb_port_arbiter: write-port mux, mdu_wb_ready, FSM, starve_cnt; exports drain and the port signals.
//  - Top: scoreboard, stall logic, bypass.
// TESTING
//  1. Issue wr r5; next cycle ID reads rs=r5 -> id_stall=1 until pipe WB rd=5.
//     - Bypass off: issue the cycle after the write.
//     - Bypass on: issue in the write cycle, byp_rs=1.
//  2. Issue wr r0 then read r0 -> never stalls; pipe WB rd=0 -> rf_we=0.
//  3. mdu_wb_valid rd=7 and pipe_wb_valid rd=3 together -> rf_wa=3, ready=0; next cycle pipe idle -> rf_wa=7, ready=1, busy[7] cleared.
//  4. pipe_wb_valid held high, STARVE_MAX=4, MDU valid -> DRAIN after 4 lost cycles; id_stall=1 until the MDU grant, then IDLE.
//  5. Busy r9; same cycle WB clears r9 and ID issues wr r9 (bypass on) -> busy[9] stays 1.
//  6. rst_n low mid-DRAIN with busy r4,r12 -> busy=0, IDLE, rf_we=0, mdu_wb_ready=0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Brief    : Shared types for the ID-stage hazard scheduler.
//  Revision : 1.0
// ============================================================================
package hazard_pkg;

    localparam int unsigned REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/id_hazard_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_hazard_sched_if
//  Brief    : ID issue, WB/MDU write-back and regfile port bundle.
//             Bypass signals exist only when ID_BYPASS_EN is defined.
//  Revision : 1.0
// ============================================================================
interface id_hazard_sched_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_wr_en;
    logic [AW-1:0] id_wr_rd;
    logic          id_stall;
    logic          id_issue;

    logic          pipe_wb_valid;
    logic [AW-1:0] pipe_wb_rd;
    logic [DW-1:0] pipe_wb_wd;

    logic          mdu_wb_valid;
    logic [AW-1:0] mdu_wb_rd;
    logic [DW-1:0] mdu_wb_wd;
    logic          mdu_wb_ready;

    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

`ifdef ID_BYPASS_EN
    logic          byp_rs;
    logic          byp_rt;
    logic [DW-1:0] byp_wd;
`endif

    // master: core pipeline side driving requests; slave: the scheduler
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_rd,
        output pipe_wb_valid, pipe_wb_rd, pipe_wb_wd,
        output mdu_wb_valid, mdu_wb_rd, mdu_wb_wd,
        input  id_stall, id_issue, mdu_wb_ready, rf_we, rf_wa, rf_wd
`ifdef ID_BYPASS_EN
        , input byp_rs, byp_rt, byp_wd
`endif
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_rd,
        input  pipe_wb_valid, pipe_wb_rd, pipe_wb_wd,
        input  mdu_wb_valid, mdu_wb_rd, mdu_wb_wd,
        output id_stall, id_issue, mdu_wb_ready, rf_we, rf_wa, rf_wd
`ifdef ID_BYPASS_EN
        , output byp_rs, byp_rt, byp_wd
`endif
    );

endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Brief    : Regfile write-port mux (pipeline priority) with an MDU
//             starvation FSM that requests ID drain after STARVE_MAX losses.
//  Revision : 1.0
// ============================================================================
module wb_port_arbiter
    import hazard_pkg::*;
#(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          pipe_wb_valid,
    input  wire logic [AW-1:0] pipe_wb_rd,
    input  wire logic [DW-1:0] pipe_wb_wd,
    input  wire logic          mdu_wb_valid,
    input  wire logic [AW-1:0] mdu_wb_rd,
    input  wire logic [DW-1:0] mdu_wb_wd,
    output logic               mdu_wb_ready,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wa,
    output logic [DW-1:0]      rf_wd,
    output logic               drain
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic [CW-1:0] w_cnt_inc;
    logic          w_lost;
    logic          w_grant;

    assign w_lost  = mdu_wb_valid & pipe_wb_valid;
    assign w_grant = mdu_wb_valid & ~pipe_wb_valid;

    // Port outputs are gated by rst_n so nothing is written while in reset.
    always_comb begin
        rf_wa        = pipe_wb_valid ? pipe_wb_rd : mdu_wb_rd;
        rf_wd        = pipe_wb_valid ? pipe_wb_wd : mdu_wb_wd;
        rf_we        = rst_n & (pipe_wb_valid | mdu_wb_valid) & (rf_wa != AW'(REG_ZERO));
        mdu_wb_ready = rst_n & w_grant;
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        w_cnt_inc    = starve_cnt_q + CW'(1);
        case (state_q)
            ARB_IDLE: begin
                if (w_lost) begin
                    starve_cnt_d = CW'(1);
                    state_d      = (STARVE_MAX == 1) ? ARB_DRAIN : ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (!mdu_wb_valid || w_grant) begin
                    state_d      = ARB_IDLE;
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = w_cnt_inc;
                    if (w_cnt_inc >= CW'(STARVE_MAX)) begin
                        state_d = ARB_DRAIN;
                    end
                end
            end
            ARB_DRAIN: begin
                if (!mdu_wb_valid || w_grant) begin
                    state_d      = ARB_IDLE;
                    starve_cnt_d = '0;
                end
            end
            default: begin
                state_d      = ARB_IDLE;
                starve_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign drain = (state_q == ARB_DRAIN);

endmodule
`default_nettype wire

// File: rtl/id_hazard_sched.sv
`default_nettype none
// ============================================================================
//  Module   : id_hazard_sched
//  Brief    : Busy-bit scoreboard, RAW/WAW stall and write-port sharing
//             around the ID regfile. Optional ID_BYPASS_EN lets ID issue
//             in the write-back cycle and exposes byp_* mux selects.
//  Revision : 1.0
// ============================================================================
module id_hazard_sched
    import hazard_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input wire logic      clk,
    input wire logic      rst_n,
    id_hazard_sched_if.slave bus
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] w_busy_eff;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_set;
    logic            w_rf_we;
    logic [AW-1:0]   w_rf_wa;
    logic [DW-1:0]   w_rf_wd;
    logic            w_mdu_ready;
    logic            w_drain;
    logic            w_raw;
    logic            w_waw;
    logic            w_stall;

    wb_port_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .pipe_wb_valid (bus.pipe_wb_valid),
        .pipe_wb_rd    (bus.pipe_wb_rd),
        .pipe_wb_wd    (bus.pipe_wb_wd),
        .mdu_wb_valid  (bus.mdu_wb_valid),
        .mdu_wb_rd     (bus.mdu_wb_rd),
        .mdu_wb_wd     (bus.mdu_wb_wd),
        .mdu_wb_ready  (w_mdu_ready),
        .rf_we         (w_rf_we),
        .rf_wa         (w_rf_wa),
        .rf_wd         (w_rf_wd),
        .drain         (w_drain)
    );

    always_comb begin
        w_clr = '0;
        if (w_rf_we) begin
            w_clr[w_rf_wa] = 1'b1;
        end
`ifdef ID_BYPASS_EN
        // The register being written right now is readable through the bypass.
        w_busy_eff = busy_q & ~w_clr;
`else
        w_busy_eff = busy_q;
`endif
        w_raw   = (bus.id_use_rs & w_busy_eff[bus.id_rs]) |
                  (bus.id_use_rt & w_busy_eff[bus.id_rt]);
        w_waw   = bus.id_wr_en & w_busy_eff[bus.id_wr_rd];
        w_stall = bus.id_valid & (w_raw | w_waw | w_drain);

        w_set = '0;
        if (bus.id_valid && !w_stall && bus.id_wr_en && (bus.id_wr_rd != AW'(REG_ZERO))) begin
            w_set[bus.id_wr_rd] = 1'b1;
        end
        // Set is OR-ed last so a same-cycle re-issue keeps the mark.
        busy_d    = (busy_q & ~w_clr) | w_set;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.id_stall     = w_stall;
    assign bus.id_issue     = bus.id_valid & ~w_stall;
    assign bus.mdu_wb_ready = w_mdu_ready;
    assign bus.rf_we        = w_rf_we;
    assign bus.rf_wa        = w_rf_wa;
    assign bus.rf_wd        = w_rf_wd;

`ifdef ID_BYPASS_EN
    assign bus.byp_rs = bus.id_use_rs & w_rf_we & (w_rf_wa == bus.id_rs);
    assign bus.byp_rt = bus.id_use_rt & w_rf_we & (w_rf_wa == bus.id_rt);
    assign bus.byp_wd = w_rf_wd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_hazard_sched
//  Brief    : Directed bench; regfile writes are checked against a queue of
//             expected write-port transactions, stall/issue checked inline.
//  Revision : 1.0
// ============================================================================
module tb_id_hazard_sched;
    import hazard_pkg::*;

    typedef struct packed {
        reg_addr_t   wa;
        logic [31:0] wd;
        logic        rdy;
    } wb_exp_t;

    logic    clk;
    logic    rst_n;
    int      total;
    int      bad;
    wb_exp_t exp_q[$];

    id_hazard_sched_if #(.AW(5), .DW(32)) bus ();

    id_hazard_sched #(
        .NREG       (32),
        .AW         (5),
        .DW         (32),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.id_valid      = 1'b0;
        bus.id_rs         = '0;
        bus.id_rt         = '0;
        bus.id_use_rs     = 1'b0;
        bus.id_use_rt     = 1'b0;
        bus.id_wr_en      = 1'b0;
        bus.id_wr_rd      = '0;
        bus.pipe_wb_valid = 1'b0;
        bus.pipe_wb_rd    = '0;
        bus.pipe_wb_wd    = '0;
        bus.mdu_wb_valid  = 1'b0;
        bus.mdu_wb_rd     = '0;
        bus.mdu_wb_wd     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input reg_addr_t rd, input logic [31:0] wd);
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_rd    = rd;
        bus.pipe_wb_wd    = wd;
        if (rd != REG_ZERO) exp_q.push_back('{wa: rd, wd: wd, rdy: 1'b0});
    endtask

    task automatic mdu(input reg_addr_t rd, input logic [31:0] wd);
        bus.mdu_wb_valid = 1'b1;
        bus.mdu_wb_rd    = rd;
        bus.mdu_wb_wd    = wd;
    endtask

    // Write-port monitor: every regfile write must match the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wb_unexpected: got wa=%0d wd=%0h expected no write",
                             bus.rf_wa, bus.rf_wd);
                end else begin
                    wb_exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_wa", 32'(bus.rf_wa), 32'(e.wa));
                    chk("wb_wd", bus.rf_wd, e.wd);
                    chk("wb_ready", 32'(bus.mdu_wb_ready), 32'(e.rdy));
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst_n = 1'b0;
        mdu(5'd7, 32'h77);
        bus.id_valid  = 1'b1;
        bus.id_use_rs = 1'b1;
        bus.id_rs     = 5'd5;
        #2;
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_mdu_ready", 32'(bus.mdu_wb_ready), 32'd0);
        chk("rst_stall", 32'(bus.id_stall), 32'd0);
        tick();
        tick();
        idle();
        rst_n = 1'b1;

        // 1: RAW on r5 until pipeline write-back
        tick();
        bus.id_valid = 1'b1; bus.id_wr_en = 1'b1; bus.id_wr_rd = 5'd5;
        @(negedge clk);
        chk("t1_issue_wr5", 32'(bus.id_issue), 32'd1);
        tick();
        idle();
        bus.id_valid = 1'b1; bus.id_use_rs = 1'b1; bus.id_rs = 5'd5;
        @(negedge clk);
        chk("t1_raw_stall", 32'(bus.id_stall), 32'd1);
        tick();
        @(negedge clk);
        chk("t1_raw_hold", 32'(bus.id_stall), 32'd1);
        tick();
        pipe(5'd5, 32'h55);
        @(negedge clk);
`ifdef ID_BYPASS_EN
        chk("t1_wb_cycle_stall", 32'(bus.id_stall), 32'd0);
        chk("t1_byp_rs", 32'(bus.byp_rs), 32'd1);
        chk("t1_byp_wd", bus.byp_wd, 32'h55);
`else
        chk("t1_wb_cycle_stall", 32'(bus.id_stall), 32'd1);
`endif
        tick();
        bus.pipe_wb_valid = 1'b0;
        @(negedge clk);
        chk("t1_after_wb_issue", 32'(bus.id_issue), 32'd1);

        // 2: r0 never busy, never written
        tick();
        idle();
        bus.id_valid = 1'b1; bus.id_wr_en = 1'b1; bus.id_wr_rd = 5'd0;
        @(negedge clk);
        chk("t2_wr_r0_stall", 32'(bus.id_stall), 32'd0);
        tick();
        bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
        pipe(5'd0, 32'hDEAD);
        @(negedge clk);
        chk("t2_rd_r0_stall", 32'(bus.id_stall), 32'd0);
        chk("t2_wb_r0_we", 32'(bus.rf_we), 32'd0);

        // 3: pipeline beats MDU, MDU granted next cycle
        tick();
        idle();
        bus.id_valid = 1'b1; bus.id_wr_en = 1'b1; bus.id_wr_rd = 5'd7;
        @(negedge clk);
        chk("t3_issue_wr7", 32'(bus.id_issue), 32'd1);
        tick();
        idle();
        bus.id_valid = 1'b1; bus.id_use_rs = 1'b1; bus.id_rs = 5'd7;
        mdu(5'd7, 32'h77);
        pipe(5'd3, 32'h33);
        @(negedge clk);
        chk("t3_lost_ready", 32'(bus.mdu_wb_ready), 32'd0);
        chk("t3_lost_wa", 32'(bus.rf_wa), 32'd3);
        chk("t3_r7_stall", 32'(bus.id_stall), 32'd1);
        tick();
        bus.pipe_wb_valid = 1'b0;
        exp_q.push_back('{wa: 5'd7, wd: 32'h77, rdy: 1'b1});
        @(negedge clk);
        chk("t3_grant_ready", 32'(bus.mdu_wb_ready), 32'd1);
`ifdef ID_BYPASS_EN
        chk("t3_grant_stall", 32'(bus.id_stall), 32'd0);
`else
        chk("t3_grant_stall", 32'(bus.id_stall), 32'd1);
`endif
        tick();
        bus.mdu_wb_valid = 1'b0;
        @(negedge clk);
        chk("t3_r7_free", 32'(bus.id_stall), 32'd0);

        // 4: starvation forces a drain after four lost cycles
        tick();
        idle();
        bus.id_valid = 1'b1;
        mdu(5'd8, 32'h88);
        for (int i = 0; i < 4; i++) begin
            pipe(reg_addr_t'(11 + i), 32'h100 + 32'(i));
            @(negedge clk);
            chk("t4_pre_drain_stall", 32'(bus.id_stall), 32'd0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            pipe(reg_addr_t'(20 + i), 32'h200 + 32'(i));
            @(negedge clk);
            chk("t4_drain_stall", 32'(bus.id_stall), 32'd1);
            chk("t4_drain_issue", 32'(bus.id_issue), 32'd0);
            tick();
        end
        bus.pipe_wb_valid = 1'b0;
        exp_q.push_back('{wa: 5'd8, wd: 32'h88, rdy: 1'b1});
        @(negedge clk);
        chk("t4_grant_stall", 32'(bus.id_stall), 32'd1);
        chk("t4_grant_ready", 32'(bus.mdu_wb_ready), 32'd1);
        tick();
        bus.mdu_wb_valid = 1'b0;
        @(negedge clk);
        chk("t4_back_idle", 32'(bus.id_stall), 32'd0);

        // 5: same-cycle clear and re-mark of r9
        tick();
        idle();
        bus.id_valid = 1'b1; bus.id_wr_en = 1'b1; bus.id_wr_rd = 5'd9;
        @(negedge clk);
        chk("t5_issue_wr9", 32'(bus.id_issue), 32'd1);
        tick();
        pipe(5'd9, 32'h99);
        @(negedge clk);
`ifdef ID_BYPASS_EN
        chk("t5_reissue_wb_cycle", 32'(bus.id_issue), 32'd1);
`else
        chk("t5_waw_wb_cycle", 32'(bus.id_stall), 32'd1);
        tick();
        bus.pipe_wb_valid = 1'b0;
        @(negedge clk);
        chk("t5_reissue_after", 32'(bus.id_issue), 32'd1);
`endif
        tick();
        idle();
        bus.id_valid = 1'b1; bus.id_use_rs = 1'b1; bus.id_rs = 5'd9;
        @(negedge clk);
        chk("t5_r9_still_busy", 32'(bus.id_stall), 32'd1);
        tick();
        pipe(5'd9, 32'h999);
        tick();
        bus.pipe_wb_valid = 1'b0;
        @(negedge clk);
        chk("t5_r9_free", 32'(bus.id_stall), 32'd0);

        // 6: async reset in DRAIN with r4/r12 busy
        tick();
        idle();
        bus.id_valid = 1'b1; bus.id_wr_en = 1'b1; bus.id_wr_rd = 5'd4;
        tick();
        bus.id_wr_rd = 5'd12;
        tick();
        idle();
        bus.id_valid = 1'b1;
        mdu(5'd2, 32'h22);
        pipe(5'd0, 32'h0);
        repeat (4) tick();
        @(negedge clk);
        chk("t6_in_drain", 32'(bus.id_stall), 32'd1);
        tick();
        bus.pipe_wb_valid = 1'b0;
        bus.id_use_rs = 1'b1; bus.id_rs = 5'd4;
        bus.id_use_rt = 1'b1; bus.id_rt = 5'd12;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("t6_rst_ready", 32'(bus.mdu_wb_ready), 32'd0);
        chk("t6_rst_stall", 32'(bus.id_stall), 32'd0);
        tick();
        bus.mdu_wb_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_busy_cleared", 32'(bus.id_stall), 32'd0);
        tick();
        mdu(5'd2, 32'h22);
        exp_q.push_back('{wa: 5'd2, wd: 32'h22, rdy: 1'b1});
        @(negedge clk);
        chk("t6_post_rst_grant", 32'(bus.mdu_wb_ready), 32'd1);
        tick();
        idle();
        tick();

        chk("wb_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
